z80_wait_gen: RTL and testbench

- Programmable wait-state generator for the Z80 glue CPLD.
- Sits directly upstream of the CPU glue block: produces the four per-cycle-type ready strobes WSxMEMRD, WSxMEMWR, WSxIORD and WSxIOWR, which the glue muxes into READY.
- Wait counts are held in two I/O-writable config registers.
- Refresh and interrupt-acknowledge cycles never get waits.

---
 rtl/z80_wait_gen.sv | 172 +++++++++++++++++
 tb/tb_z80_wait_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/z80_wait_gen.sv
// ---------------------------------------------------------------------------
// z80_wait_gen
// Programmable wait-state generator for the Z80 glue CPLD. Each bus cycle is
// classified as memory read, memory write, I/O read or I/O write, and the ready
// strobe for that type is held low for a programmable number of clock edges.
// Refresh and interrupt-acknowledge cycles never get waits.
//
// Ports:
//   CLK          CPU clock, all state changes on the rising edge
//   nCPUxRESET   asynchronous active-low reset
//   nCPUxMREQ, nCPUxIORQ, nCPUxRD, nCPUxWR, nCPUxM1, nCPUxRFSH
//                Z80 bus control inputs (active low)
//   nCSxWS       active-low decode of the two config register I/O ports
//   CPU_ADDR0    config register select (0 = memory, 1 = I/O)
//   CPU_D        CPU data bus, written into the selected config register
//   WSxMEMRD, WSxMEMWR, WSxIORD, WSxIOWR
//                per-type ready strobes (1 = ready)
//   WSxBUSY      1 while the state machine is counting waits
// ---------------------------------------------------------------------------
module z80_wait_gen #(
  parameter logic [3:0] DEF_MEMRD = 4'd0,
  parameter logic [3:0] DEF_MEMWR = 4'd0,
  parameter logic [3:0] DEF_IORD  = 4'd2,
  parameter logic [3:0] DEF_IOWR  = 4'd2
) (
  input  logic       CLK,
  input  logic       nCPUxRESET,
  input  logic       nCPUxMREQ,
  input  logic       nCPUxIORQ,
  input  logic       nCPUxRD,
  input  logic       nCPUxWR,
  input  logic       nCPUxM1,
  input  logic       nCPUxRFSH,
  input  logic       nCSxWS,
  input  logic       CPU_ADDR0,
  input  logic [7:0] CPU_D,
  output logic       WSxMEMRD,
  output logic       WSxMEMWR,
  output logic       WSxIORD,
  output logic       WSxIOWR,
  output logic       WSxBUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] type_q;
  logic       we_q;
  logic [7:0] cfg_mem_q;   // {MEMWR, MEMRD}
  logic [7:0] cfg_io_q;    // {IOWR, IORD}

  logic       act;
  logic       we;
  logic       cfg_wr;
  logic [1:0] type_live;
  logic [3:0] n_live;
  logic       strobe_low;
  logic [1:0] strobe_type;
  logic [3:0] ws_n;

  // Refresh (/MREQ with /RFSH) and INTA (/IORQ with /M1) are excluded here,
  // which is all it takes to keep them wait-free.
  assign act       = (~nCPUxMREQ & nCPUxRFSH) | (~nCPUxIORQ & nCPUxM1);
  assign type_live = {nCPUxMREQ, nCPUxRD};

  assign we     = ~nCSxWS & ~nCPUxIORQ & ~nCPUxWR & nCPUxM1;
  // Rising edge of the write strobe: exactly one register write per bus cycle.
  assign cfg_wr = we & ~we_q;

  always_comb begin
    n_live = 4'd0;
    case (type_live)
      2'b00:   n_live = cfg_mem_q[3:0];
      2'b01:   n_live = cfg_mem_q[7:4];
      2'b10:   n_live = cfg_io_q[3:0];
      default: n_live = cfg_io_q[7:4];
    endcase
  end

  // Config registers. The state machine samples n_live on the same edge that
  // a write lands, so a cycle that writes the registers still waits with the
  // old count.
  always_ff @(posedge CLK or negedge nCPUxRESET) begin
    if (!nCPUxRESET) begin
      we_q      <= 1'b0;
      cfg_mem_q <= {DEF_MEMWR, DEF_MEMRD};
      cfg_io_q  <= {DEF_IOWR, DEF_IORD};
    end else begin
      we_q <= we;
      if (cfg_wr) begin
        if (CPU_ADDR0) cfg_io_q  <= CPU_D;
        else           cfg_mem_q <= CPU_D;
      end
    end
  end

  // Wait-state machine.
  always_ff @(posedge CLK or negedge nCPUxRESET) begin
    if (!nCPUxRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      type_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (act) begin
            type_q <= type_live;
            if (n_live == 4'd0) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= n_live - 4'd1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!act) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (!act) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The first wait edge is produced from IDLE using the live type; the
  // remaining N-1 come from WAIT using the latched type. Gating with act makes
  // an aborted cycle release the strobe immediately, and gating with the reset
  // keeps every strobe high while reset is held.
  always_comb begin
    strobe_low  = 1'b0;
    strobe_type = type_q;
    case (state_q)
      S_IDLE: begin
        strobe_low  = act & (n_live != 4'd0);
        strobe_type = type_live;
      end
      S_WAIT: begin
        strobe_low  = act & (cnt_q != 4'd0);
        strobe_type = type_q;
      end
      default: begin
        strobe_low  = 1'b0;
        strobe_type = type_q;
      end
    endcase
  end

  always_comb begin
    ws_n = 4'hF;
    if (strobe_low && nCPUxRESET) ws_n[strobe_type] = 1'b0;
  end

  assign WSxMEMRD = ws_n[0];
  assign WSxMEMWR = ws_n[1];
  assign WSxIORD  = ws_n[2];
  assign WSxIOWR  = ws_n[3];
  assign WSxBUSY  = (state_q == S_WAIT);

endmodule

// File: tb/tb_z80_wait_gen.sv
module tb_z80_wait_gen;

  logic       CLK = 1'b0;
  logic       nCPUxRESET = 1'b0;
  logic       nCPUxMREQ = 1'b1;
  logic       nCPUxIORQ = 1'b1;
  logic       nCPUxRD = 1'b1;
  logic       nCPUxWR = 1'b1;
  logic       nCPUxM1 = 1'b1;
  logic       nCPUxRFSH = 1'b1;
  logic       nCSxWS = 1'b1;
  logic       CPU_ADDR0 = 1'b0;
  logic [7:0] CPU_D = 8'h00;
  logic       WSxMEMRD, WSxMEMWR, WSxIORD, WSxIOWR, WSxBUSY;
  logic [3:0] ws;

  int checks = 0;
  int errors = 0;

  z80_wait_gen dut (
    .CLK(CLK), .nCPUxRESET(nCPUxRESET),
    .nCPUxMREQ(nCPUxMREQ), .nCPUxIORQ(nCPUxIORQ),
    .nCPUxRD(nCPUxRD), .nCPUxWR(nCPUxWR),
    .nCPUxM1(nCPUxM1), .nCPUxRFSH(nCPUxRFSH),
    .nCSxWS(nCSxWS), .CPU_ADDR0(CPU_ADDR0), .CPU_D(CPU_D),
    .WSxMEMRD(WSxMEMRD), .WSxMEMWR(WSxMEMWR),
    .WSxIORD(WSxIORD), .WSxIOWR(WSxIOWR), .WSxBUSY(WSxBUSY)
  );

  // Index matches the cycle type {nMREQ, nRD}.
  assign ws = {WSxIOWR, WSxIORD, WSxMEMWR, WSxMEMRD};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
    $display("check %-16s got %0h expected %0h", tag, got, exp);
  endtask

  task automatic bus_idle();
    nCPUxMREQ = 1'b1; nCPUxIORQ = 1'b1; nCPUxRD = 1'b1; nCPUxWR = 1'b1;
    nCPUxM1 = 1'b1; nCPUxRFSH = 1'b1; nCSxWS = 1'b1;
  endtask

  // Runs one bus cycle of n clock edges. Each sample is taken 1 ns after a
  // falling edge, i.e. the value the next rising edge will see. CPU_D is
  // replaced by d_late after the first rising edge.
  task automatic bus_cycle(input logic mreq, input logic iorq, input logic rd,
                           input logic wr, input logic m1, input logic rfsh,
                           input logic cs, input logic a0,
                           input logic [7:0] d, input logic [7:0] d_late,
                           input int n, output int lows,
                           output logic [3:0] and_ws, output logic busy_seen);
    logic [1:0] tgt;
    @(negedge CLK);
    nCPUxMREQ = mreq; nCPUxIORQ = iorq; nCPUxRD = rd; nCPUxWR = wr;
    nCPUxM1 = m1; nCPUxRFSH = rfsh; nCSxWS = cs; CPU_ADDR0 = a0; CPU_D = d;
    tgt = {mreq, rd};
    lows = 0; and_ws = 4'hF; busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (ws[tgt] == 1'b0) lows++;
      and_ws = and_ws & ws;
      busy_seen = busy_seen | WSxBUSY;
      @(negedge CLK);
      if (i == 0) CPU_D = d_late;
    end
    bus_idle();
    #1;
  endtask

  int         lows;
  logic [3:0] aw;
  logic       bz;

  initial begin
    // Reset state
    @(negedge CLK); @(negedge CLK);
    #1;
    chk("rst_ws", {28'd0, ws}, 32'hF);
    chk("rst_busy", {31'd0, WSxBUSY}, 32'd0);
    nCPUxRESET = 1'b1;

    // 1: I/O read with defaults -> 2 waits
    bus_cycle(1, 0, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 5, lows, aw, bz);
    chk("t1_iord_lows", lows, 2);
    chk("t1_others", {28'd0, aw | 4'b0100}, 32'hF);
    chk("t1_busy_seen", {31'd0, bz}, 32'd1);
    chk("t1_end_ws", {28'd0, ws}, 32'hF);

    // 2: write REG0=0x3F (cycle itself waits IOWR=2), then MEMRD 15, MEMWR 3
    bus_cycle(1, 0, 1, 0, 1, 1, 0, 0, 8'h3F, 8'h3F, 5, lows, aw, bz);
    chk("t2_wr_lows", lows, 2);
    bus_cycle(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 18, lows, aw, bz);
    chk("t2_memrd_lows", lows, 15);
    chk("t2_memrd_others", {28'd0, aw | 4'b0001}, 32'hF);
    bus_cycle(0, 1, 1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 6, lows, aw, bz);
    chk("t2_memwr_lows", lows, 3);

    // 3: refresh and INTA -> no waits, never busy
    bus_cycle(0, 1, 1, 1, 1, 0, 1, 0, 8'h00, 8'h00, 5, lows, aw, bz);
    chk("t3_rfsh_ws", {28'd0, aw}, 32'hF);
    chk("t3_rfsh_busy", {31'd0, bz}, 32'd0);
    bus_cycle(1, 0, 1, 1, 0, 1, 1, 0, 8'h00, 8'h00, 5, lows, aw, bz);
    chk("t3_inta_ws", {28'd0, aw}, 32'hF);
    chk("t3_inta_busy", {31'd0, bz}, 32'd0);

    // 4: REG0=0x35, aborted memory read after 2 edges, then a full one
    bus_cycle(1, 0, 1, 0, 1, 1, 0, 0, 8'h35, 8'h35, 4, lows, aw, bz);
    bus_cycle(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 2, lows, aw, bz);
    chk("t4_abort_lows", lows, 2);
    chk("t4_abort_memrd", {31'd0, WSxMEMRD}, 32'd1);
    @(negedge CLK); #1;
    chk("t4_abort_busy", {31'd0, WSxBUSY}, 32'd0);
    bus_cycle(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 8, lows, aw, bz);
    chk("t4_memrd_lows", lows, 5);

    // 5: REG1=0x00 during an IOWR cycle; a later data change must not be written
    bus_cycle(1, 0, 1, 0, 1, 1, 0, 1, 8'h00, 8'h22, 5, lows, aw, bz);
    chk("t5_wr_lows", lows, 2);
    bus_cycle(1, 0, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 4, lows, aw, bz);
    chk("t5_iord_lows", lows, 0);
    bus_cycle(1, 0, 1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 4, lows, aw, bz);
    chk("t5_iowr_lows", lows, 0);

    // 6: reset asserted mid-WAIT of a 5-wait memory read
    @(negedge CLK);
    nCPUxMREQ = 1'b0; nCPUxRD = 1'b0;
    @(negedge CLK); @(negedge CLK); #1;
    chk("t6_pre_busy", {31'd0, WSxBUSY}, 32'd1);
    chk("t6_pre_memrd", {31'd0, WSxMEMRD}, 32'd0);
    #1 nCPUxRESET = 1'b0;
    #1;
    chk("t6_rst_ws", {28'd0, ws}, 32'hF);
    chk("t6_rst_busy", {31'd0, WSxBUSY}, 32'd0);
    @(negedge CLK);
    bus_idle();
    #1 nCPUxRESET = 1'b1;
    bus_cycle(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 4, lows, aw, bz);
    chk("t6_memrd_lows", lows, 0);
    bus_cycle(0, 1, 1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 4, lows, aw, bz);
    chk("t6_memwr_lows", lows, 0);
    bus_cycle(1, 0, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 5, lows, aw, bz);
    chk("t6_iord_lows", lows, 2);
    bus_cycle(1, 0, 1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 5, lows, aw, bz);
    chk("t6_iowr_lows", lows, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
